hilo_divider: RTL and testbench

Iterative radix-2 divider that executes MIPS `div`/`divu` and holds the HI/LO result registers read back through `mfhi`/`mflo`. It sits beside the ALU in the EX stage. The ALU launches a divide when it decodes `Funct_Div`/`Funct_Divu`, and consumes `Hi`/`Lo` when it decodes `Funct_Mfhi`/`Funct_Mflo`. The pipeline stalls while `Busy` is high.

---
 rtl/hilo_divider.sv | 135 +++++++++++++
 tb/tb_hilo_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_divider.sv
// hilo_divider: iterative radix-2 divider for MIPS div/divu that owns the HI/LO registers.
// One quotient bit per cycle; signs are stripped on entry and restored in a single fix-up cycle.
`default_nettype none

module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic             zero;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    a_neg   = Signed & A[WIDTH-1];
    b_neg   = Signed & B[WIDTH-1];
    abs_a   = a_neg ? -A : A;
    abs_b   = b_neg ? -B : B;
    // Remainder gets one extra bit so the trial subtract never wraps.
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = ~diff[WIDTH];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start) state_next = (B == '0) ? FIX : CALC;
      CALC: if (count == '0) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      zero      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (B == '0) begin
              // Raw dividend parked in rem so FIX can return it untouched in Hi.
              zero  <= 1'b1;
              rem   <= A;
              quo   <= '0;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              zero  <= 1'b0;
              rem   <= '0;
              quo   <= abs_a;
              dvs   <= abs_b;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              count <= CW'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          if (count != '0) count <= count - 1'b1;
        end
        FIX: begin
          Done      <= 1'b1;
          DivByZero <= zero;
          if (zero) begin
            Hi <= rem;
            Lo <= '1;
          end else begin
            Hi <= r_neg ? -rem : rem;
            Lo <= q_neg ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: directed MIPS div/divu cases plus a random regression.
`default_nettype none

module tb_hilo_divider;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic         Signed = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int total  = 0;
  int passed = 0;

  hilo_divider #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result from the architectural definition of div/divu.
  task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, q, r;
    dz = (b == '0);
    if (dz) begin
      hi = a;
      lo = '1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Issue one divide, wait (bounded) for Done; returns latency in edges after the sampling edge.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cycles);
    Start = 1'b1; Signed = sgn; A = a; B = b;
    tick();
    Start = 1'b0; A = $urandom; B = $urandom; Signed = $urandom_range(0, 1);
    lat = 0;
    busy_cycles = Busy ? 1 : 0;
    while (!Done && lat < 100) begin
      tick();
      lat++;
      if (Busy) busy_cycles++;
    end
  endtask

  task automatic div_check(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0] hi, lo;
    logic dz;
    int lat, bc;
    ref_div(sgn, a, b, hi, lo, dz);
    run_div(sgn, a, b, lat, bc);
    check({tag, ".done"}, 64'(Done), 64'(1));
    check({tag, ".lo"}, 64'(Lo), 64'(lo));
    check({tag, ".hi"}, 64'(Hi), 64'(hi));
    check({tag, ".dz"}, 64'(DivByZero), 64'(dz));
  endtask

  initial begin
    int lat, bc;
    logic [W-1:0] ra, rb;
    logic rs;
    bit saw_done;

    tick(); tick();
    check("rst.busy", 64'(Busy), 64'(0));
    check("rst.done", 64'(Done), 64'(0));
    check("rst.dz",   64'(DivByZero), 64'(0));
    check("rst.hi",   64'(Hi), 64'(0));
    check("rst.lo",   64'(Lo), 64'(0));
    Reset = 1'b1;
    tick();

    // 6/3 with latency and busy-length checks, then single-cycle Done.
    run_div(1'b0, 32'd6, 32'd3, lat, bc);
    check("u6_3.lat",  64'(lat), 64'(33));
    check("u6_3.busy", 64'(bc), 64'(33));
    check("u6_3.lo",   64'(Lo), 64'(2));
    check("u6_3.hi",   64'(Hi), 64'(0));
    tick();
    check("u6_3.done_pulse", 64'(Done), 64'(0));
    check("u6_3.hold_lo", 64'(Lo), 64'(2));

    run_div(1'b0, 32'd11, 32'd3, lat, bc);
    check("u11_3.busy", 64'(bc), 64'(33));
    check("u11_3.lo", 64'(Lo), 64'(3));
    check("u11_3.hi", 64'(Hi), 64'(2));

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc);
    check("s-7_2.lo", 64'(Lo), 64'(32'hFFFF_FFFD));
    check("s-7_2.hi", 64'(Hi), 64'(32'hFFFF_FFFF));
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc);
    check("s7_-2.lo", 64'(Lo), 64'(32'hFFFF_FFFD));
    check("s7_-2.hi", 64'(Hi), 64'(1));
    run_div(1'b0, 32'hFFFF_FFFF, 32'd2, lat, bc);
    check("umax_2.lo", 64'(Lo), 64'(32'h7FFF_FFFF));
    check("umax_2.hi", 64'(Hi), 64'(1));
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    check("sovf.lo", 64'(Lo), 64'(32'h8000_0000));
    check("sovf.hi", 64'(Hi), 64'(0));

    // Divide by zero: one busy cycle, Done right after.
    run_div(1'b0, 32'd5, 32'd0, lat, bc);
    check("dz.lat", 64'(lat), 64'(1));
    check("dz.busy", 64'(bc), 64'(1));
    check("dz.flag", 64'(DivByZero), 64'(1));
    check("dz.hi", 64'(Hi), 64'(5));
    check("dz.lo", 64'(Lo), 64'(32'hFFFF_FFFF));
    run_div(1'b0, 32'd9, 32'd4, lat, bc);
    check("after_dz.flag", 64'(DivByZero), 64'(0));
    check("after_dz.lo", 64'(Lo), 64'(2));
    check("after_dz.hi", 64'(Hi), 64'(1));

    // Reset in the middle of 10/3.
    Start = 1'b1; Signed = 1'b0; A = 32'd10; B = 32'd3;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Reset = 1'b0;
    tick();
    check("midrst.busy", 64'(Busy), 64'(0));
    check("midrst.done", 64'(Done), 64'(0));
    check("midrst.dz",   64'(DivByZero), 64'(0));
    check("midrst.hi",   64'(Hi), 64'(0));
    check("midrst.lo",   64'(Lo), 64'(0));
    Reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (Done) saw_done = 1'b1;
    end
    check("midrst.no_done", 64'(saw_done), 64'(0));
    run_div(1'b0, 32'd11, 32'd3, lat, bc);
    check("midrst.next_hi", 64'(Hi), 64'(2));

    // Start pulsed while busy must be ignored.
    Start = 1'b1; Signed = 1'b0; A = 32'd6; B = 32'd3;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    Start = 1'b1; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin tick(); lat++; end
    check("ignore.done", 64'(Done), 64'(1));
    check("ignore.lo", 64'(Lo), 64'(2));
    tick();
    check("ignore.idle", 64'(Busy), 64'(0));

    // Back-to-back: Start presented during the Done cycle is accepted.
    run_div(1'b0, 32'd20, 32'd6, lat, bc);
    check("b2b.first_lo", 64'(Lo), 64'(3));
    run_div(1'b0, 32'd100, 32'd7, lat, bc);
    check("b2b.lat", 64'(lat), 64'(33));
    check("b2b.lo", 64'(Lo), 64'(14));
    check("b2b.hi", 64'(Hi), 64'(2));

    // Random regression, including occasional zero and small divisors.
    for (int i = 0; i < 500; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = $urandom_range(1, 20);
        4:       rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = $urandom_range(0, 50);
      div_check($sformatf("rnd%0d", i), rs, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
